cordic_phase_fold: RTL and testbench

//  Front end of the CORDIC sine/cosine path, feeding select_quarter.
//  - Holds the NCO phase accumulator.
//  - Splits each phase into a 2-bit quarter and a first-quadrant angle for the CORDIC core.
//  - Delays the quarter by the CORDIC pipeline latency, so the output quarter stage gets the code that matches each X/Y pair.

---
 rtl/cordic_pkg.sv | 27 ++
 rtl/cordic_phase_fold_if.sv | 26 ++
 rtl/quarter_delay_line.sv | 34 +++
 rtl/cordic_phase_fold.sv | 83 ++++++++
 tb/tb_cordic_phase_fold.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC sine/cosine path: quarter codes, mirror rule,
// and the width constants that cordic_phase_fold and select_quarter must agree on.
package cordic_pkg;

    typedef enum logic [1:0] {
        Q1 = 2'b00,
        Q2 = 2'b01,
        Q3 = 2'b10,
        Q4 = 2'b11
    } quarter_t;

    localparam int QUARTER_W      = 2;
    localparam int DLY_W          = QUARTER_W + 1;
    localparam int CORDIC_PHASE_W = 16;
    localparam int CORDIC_ANGLE_W = 13;
    localparam int CORDIC_LAT_DEF = 13;

    // Odd quarters run the angle backwards, so their first-quadrant angle is mirrored.
    function automatic logic is_mirror(input logic [QUARTER_W-1:0] q);
        return q[0];
    endfunction

    function automatic bit widths_ok(input int phase_w, input int angle_w);
        return (phase_w - 2) >= angle_w;
    endfunction

endpackage

// File: rtl/cordic_phase_fold_if.sv
// Sample-side bus of cordic_phase_fold: phase control inputs and the reduced-angle /
// delayed-quarter outputs. master drives the controls, slave is the fold block.
interface cordic_phase_fold_if #(
    parameter int PHASE_W = 16,
    parameter int ANGLE_W = 13
);
    logic               en;
    logic [PHASE_W-1:0] freq_word;
    logic               phase_load;
    logic [PHASE_W-1:0] phase_init;
    logic [ANGLE_W-1:0] angle_o;
    logic [1:0]         quarter_o;
    logic               valid_o;
    logic [1:0]         quarter_dly_o;
    logic               valid_dly_o;

    modport master (
        output en, freq_word, phase_load, phase_init,
        input  angle_o, quarter_o, valid_o, quarter_dly_o, valid_dly_o
    );

    modport slave (
        input  en, freq_word, phase_load, phase_init,
        output angle_o, quarter_o, valid_o, quarter_dly_o, valid_dly_o
    );
endinterface

// File: rtl/quarter_delay_line.sv
// Free-running DEPTH-stage shift register carrying {valid, quarter} alongside the
// CORDIC core; synchronous reset clears every stage so no stale valid survives.
module quarter_delay_line #(
    parameter int DEPTH = 13,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    logic [DEPTH-1:0][W-1:0] stage_reg;
    logic [DEPTH-1:0][W-1:0] stage_next;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_next[gi] = din;
            end else begin : g_body
                assign stage_next[gi] = stage_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= stage_next;
        end
    end

    assign dout = stage_reg[DEPTH-1];
endmodule

// File: rtl/cordic_phase_fold.sv
// NCO phase accumulator and quadrant fold feeding the CORDIC core, plus the quarter
// delay line for select_quarter. Define FOLD_ROUND_EN for round-half-up angle reduction.
module cordic_phase_fold
    import cordic_pkg::*;
#(
    parameter int PHASE_W    = CORDIC_PHASE_W,
    parameter int ANGLE_W    = CORDIC_ANGLE_W,
    parameter int CORDIC_LAT = CORDIC_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    cordic_phase_fold_if.slave bus
);
    localparam int SHIFT = PHASE_W - 2 - ANGLE_W;

    logic [PHASE_W-1:0]   phase_reg;
    logic [ANGLE_W-1:0]   angle_reg;
    logic [QUARTER_W-1:0] quarter_reg;
    logic                 valid_reg;

    logic [PHASE_W-3:0]   res_next;
    logic [ANGLE_W-1:0]   angle_next;
    logic [DLY_W-1:0]     dly_out;

    // Position within the quarter turn, mirrored for odd quarters.
    always_comb begin
        res_next = phase_reg[PHASE_W-3:0];
        if (is_mirror(phase_reg[PHASE_W-1:PHASE_W-2])) begin
            res_next = ~phase_reg[PHASE_W-3:0];
        end
    end

`ifdef FOLD_ROUND_EN
    generate
        if (SHIFT > 0) begin : g_round
            logic [ANGLE_W:0] sum_next;
            assign sum_next   = {1'b0, ANGLE_W'(res_next >> SHIFT)}
                              + {{ANGLE_W{1'b0}}, res_next[SHIFT-1]};
            // Rounding the top code up would wrap to zero; clamp at full scale instead.
            assign angle_next = sum_next[ANGLE_W] ? {ANGLE_W{1'b1}} : sum_next[ANGLE_W-1:0];
        end else begin : g_exact
            assign angle_next = ANGLE_W'(res_next);
        end
    endgenerate
`else
    assign angle_next = ANGLE_W'(res_next >> SHIFT);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg   <= '0;
            angle_reg   <= '0;
            quarter_reg <= '0;
            valid_reg   <= 1'b0;
        end else if (bus.phase_load) begin
            phase_reg <= bus.phase_init;
            valid_reg <= 1'b0;
        end else if (bus.en) begin
            quarter_reg <= phase_reg[PHASE_W-1:PHASE_W-2];
            angle_reg   <= angle_next;
            valid_reg   <= 1'b1;
            phase_reg   <= phase_reg + bus.freq_word;
        end else begin
            valid_reg <= 1'b0;
        end
    end

    quarter_delay_line #(
        .DEPTH (CORDIC_LAT),
        .W     (DLY_W)
    ) u_quarter_delay_line (
        .clk  (clk),
        .rst  (rst),
        .din  ({valid_reg, quarter_reg}),
        .dout (dly_out)
    );

    assign bus.angle_o       = angle_reg;
    assign bus.quarter_o     = quarter_reg;
    assign bus.valid_o       = valid_reg;
    assign bus.quarter_dly_o = dly_out[QUARTER_W-1:0];
    assign bus.valid_dly_o   = dly_out[QUARTER_W];
endmodule

// File: tb/tb_cordic_phase_fold.sv
// Self-checking bench for cordic_phase_fold: directed vector table, latency/reset
// sequences and a randomized run against an arithmetic reference model.
module tb_cordic_phase_fold;
    localparam int LAT = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cordic_phase_fold_if #(.PHASE_W(16), .ANGLE_W(13)) bus ();

    cordic_phase_fold #(.PHASE_W(16), .ANGLE_W(13), .CORDIC_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit ld;
        int init;
        int fw;
        bit en;
        bit exp_valid;
        int exp_q;
        int exp_angle;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state
    int m_phase = 0, m_angle = 0, m_q = 0, m_valid = 0, exp_dly = 0;
    int pipe[$];

    function automatic vec_t mkv(bit ld, int init, int fw, bit en, bit v, int q, int a);
        vec_t t;
        t.ld = ld; t.init = init; t.fw = fw; t.en = en;
        t.exp_valid = v; t.exp_q = q; t.exp_angle = a;
        return t;
    endfunction

    // Quarter-turn position, mirrored in odd quarters, scaled from 14 to 13 bits.
    function automatic int ref_angle(int ph);
        int q    = ph / 16384;
        int frac = ph % 16384;
        if (q % 2 == 1) frac = 16383 - frac;
`ifdef FOLD_ROUND_EN
        frac = (frac + 1) / 2;
        if (frac > 8191) frac = 8191;
`else
        frac = frac / 2;
`endif
        return frac;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit l, input int init, input int fw, input bit e);
        logic [31:0] iw, fww;
        iw = init; fww = fw;
        rst            = r;
        bus.phase_load = l;
        bus.phase_init = iw[15:0];
        bus.freq_word  = fww[15:0];
        bus.en         = e;
        @(posedge clk);
        #1;
        if (r) begin
            m_phase = 0; m_angle = 0; m_q = 0; m_valid = 0; exp_dly = 0;
            pipe = {};
            repeat (LAT - 1) pipe.push_back(0);
        end else begin
            pipe.push_back(m_valid * 4 + m_q);
            exp_dly = pipe.pop_front();
            if (l) begin
                m_phase = init % 65536;
                m_valid = 0;
            end else if (e) begin
                m_q     = m_phase / 16384;
                m_angle = ref_angle(m_phase);
                m_valid = 1;
                m_phase = (m_phase + fw) % 65536;
            end else begin
                m_valid = 0;
            end
        end
        chk("valid_o", 32'(bus.valid_o), 32'(m_valid));
        chk("angle_o", 32'(bus.angle_o), 32'(m_angle));
        chk("quarter_o", 32'(bus.quarter_o), 32'(m_q));
        chk("valid_dly_o", 32'(bus.valid_dly_o), 32'(exp_dly / 4));
        if (exp_dly / 4 == 1) chk("quarter_dly_o", 32'(bus.quarter_dly_o), 32'(exp_dly % 4));
        $display("cyc rst=%0d ld=%0d en=%0d -> v=%0d q=%0d a=0x%04h vd=%0d qd=%0d",
                 r, l, e, bus.valid_o, bus.quarter_o, bus.angle_o, bus.valid_dly_o, bus.quarter_dly_o);
    endtask

    // Idle until valid_dly_o rises; returns the edge count from the en edge (en edge = 1).
    task automatic measure_dly(output int first_seen, output int highs);
        first_seen = -1;
        highs = 0;
        for (int k = 2; k <= 24; k++) begin
            step(1'b0, 1'b0, 0, 0, 1'b0);
            if (bus.valid_dly_o === 1'b1) begin
                if (first_seen < 0) first_seen = k;
                highs++;
            end
        end
    endtask

    initial begin
        int first_seen, highs;
        bus.en = 1'b0; bus.phase_load = 1'b0; bus.phase_init = '0; bus.freq_word = '0;

        // Directed table: sweep, wrap, load+en, rounding corners
        tbl.push_back(mkv(0, 0, 16'h1000, 1, 1, 0, 16'h0000));
        tbl.push_back(mkv(0, 0, 16'h1000, 1, 1, 0, 16'h0800));
        tbl.push_back(mkv(0, 0, 16'h1000, 1, 1, 0, 16'h1000));
        tbl.push_back(mkv(0, 0, 16'h1000, 1, 1, 0, 16'h1800));
        tbl.push_back(mkv(0, 0, 16'h1000, 1, 1, 1, 16'h1FFF));
`ifdef FOLD_ROUND_EN
        tbl.push_back(mkv(0, 0, 16'h1000, 1, 1, 1, 16'h1800));
`else
        tbl.push_back(mkv(0, 0, 16'h1000, 1, 1, 1, 16'h17FF));
`endif
        tbl.push_back(mkv(1, 16'hFFF0, 16'h0020, 0, 0, 0, 0));
`ifdef FOLD_ROUND_EN
        tbl.push_back(mkv(0, 0, 16'h0020, 1, 1, 3, 16'h0008));
`else
        tbl.push_back(mkv(0, 0, 16'h0020, 1, 1, 3, 16'h0007));
`endif
        tbl.push_back(mkv(0, 0, 16'h0020, 1, 1, 0, 16'h0008));
        tbl.push_back(mkv(1, 16'h4000, 16'h0000, 1, 0, 0, 0));
        tbl.push_back(mkv(0, 0, 16'h0000, 1, 1, 1, 16'h1FFF));
        tbl.push_back(mkv(1, 16'h0001, 16'h0000, 0, 0, 0, 0));
`ifdef FOLD_ROUND_EN
        tbl.push_back(mkv(0, 0, 16'h0000, 1, 1, 0, 16'h0001));
`else
        tbl.push_back(mkv(0, 0, 16'h0000, 1, 1, 0, 16'h0000));
`endif
        tbl.push_back(mkv(1, 16'h3FFF, 16'h0000, 0, 0, 0, 0));
        tbl.push_back(mkv(0, 0, 16'h0000, 1, 1, 0, 16'h1FFF));

        step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < tbl.size(); i++) begin
            step(1'b0, tbl[i].ld, tbl[i].init, tbl[i].fw, tbl[i].en);
            chk($sformatf("tbl%0d_valid", i), 32'(bus.valid_o), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                chk($sformatf("tbl%0d_q", i), 32'(bus.quarter_o), 32'(tbl[i].exp_q));
                chk($sformatf("tbl%0d_angle", i), 32'(bus.angle_o), 32'(tbl[i].exp_angle));
            end
        end

        // Align: single en from phase 0x8000, delayed valid must be one cycle wide at edge 14
        step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b0, 1'b1, 16'h8000, 0, 1'b0);
        step(1'b0, 1'b0, 0, 16'h0100, 1'b1);
        chk("align_valid", 32'(bus.valid_o), 32'd1);
        chk("align_q", 32'(bus.quarter_o), 32'd2);
        measure_dly(first_seen, highs);
        chk("align_latency", 32'(first_seen), 32'(LAT + 1));
        chk("align_width", 32'(highs), 32'd1);

        // Reset mid-stream at cycle 20
        step(1'b1, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 0, $urandom_range(16'hFFFF), 1'b1);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_valid_dly", 32'(bus.valid_dly_o), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 0, 1'b0);
        step(1'b0, 1'b0, 0, 16'h2345, 1'b1);
        measure_dly(first_seen, highs);
        chk("rst_dly_latency", 32'(first_seen), 32'(LAT + 1));
        chk("rst_dly_width", 32'(highs), 32'd1);

        // Randomized run against the reference model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(99) < 2, $urandom_range(99) < 6, $urandom_range(16'hFFFF),
                 $urandom_range(16'hFFFF), $urandom_range(99) < 70);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
